qpsk_demap: RTL and testbench

QPSK_DEMAP -- requirements
Module: qpsk_demap

---
 rtl/qpsk_demap_pkg.sv | 28 ++
 rtl/qpsk_demap_bitpack.sv | 75 +++++++
 rtl/qpsk_demap.sv | 168 ++++++++++++++++
 tb/tb_qpsk_demap.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_demap_pkg.sv
// Shared constants, allocation codes and FSM encoding for the QPSK hard demapper.
package qpsk_demap_pkg;

    // Default number of used subcarriers per OFDM symbol
    localparam int NCAR = 200;

    // Data-carrier bit pairs packed into one 32-bit output word
    localparam int WORD_PAIRS = 16;

    // Two-bit allocation codes; 2'b11 is also a data carrier
    localparam logic [1:0] ALLOC_NULL  = 2'b00;
    localparam logic [1:0] ALLOC_DATA  = 2'b01;
    localparam logic [1:0] ALLOC_PILOT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FLUSH = 3'd4
    } state_e;

    // True for the codes that carry payload bits (01 and 11)
    function automatic logic is_data(input logic [1:0] code);
        return (code != ALLOC_NULL) && (code != ALLOC_PILOT);
    endfunction

endpackage

// File: rtl/qpsk_demap_bitpack.sv
// Packs 2-bit hard decisions LSB-first into 32-bit words and owns the output
// word register, including the back-pressure hold and partial-word flush.
module qpsk_bitpack
    import qpsk_demap_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [1:0]  pair,
    input  logic        flush,
    input  logic        ack,
    output logic [31:0] word,
    output logic        word_vld,
    output logic [3:0]  fill,
    output logic        halt
);

    localparam logic [3:0] FILL_LAST = 4'(WORD_PAIRS - 1);

    logic [31:0] acc_r;
    logic [3:0]  fill_r;
    logic [31:0] word_r;
    logic        vld_r;

    logic [31:0] acc_next_s;
    logic        hold_s;
    logic        full_s;
    logic        flush_go_s;
    logic        emit_s;

    // Next accumulator image and word-complete / flush decisions
    always_comb begin
        acc_next_s = acc_r;
        acc_next_s[{fill_r, 1'b0} +: 2] = pair;
        hold_s     = vld_r & ~ack;
        full_s     = push & (fill_r == FILL_LAST);
        flush_go_s = flush & (fill_r != 4'd0) & ~hold_s;
        emit_s     = full_s | flush_go_s;
    end

    // Accumulator, fill counter and output word register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r  <= 32'd0;
            fill_r <= 4'd0;
            word_r <= 32'd0;
            vld_r  <= 1'b0;
        end else begin
            if (full_s) begin
                word_r <= acc_next_s;
                acc_r  <= 32'd0;
                fill_r <= 4'd0;
            end else if (flush_go_s) begin
                word_r <= acc_r;
                acc_r  <= 32'd0;
                fill_r <= 4'd0;
            end else if (push) begin
                acc_r  <= acc_next_s;
                fill_r <= fill_r + 4'd1;
            end
            // A word completing in the same cycle as the ack keeps valid high
            if (emit_s) begin
                vld_r <= 1'b1;
            end else if (ack) begin
                vld_r <= 1'b0;
            end
        end
    end

    assign word     = word_r;
    assign word_vld = vld_r;
    assign fill     = fill_r;
    assign halt     = hold_s;

endmodule

// File: rtl/qpsk_demap.sv
// QPSK hard demapper: walks the latched carrier allocation, accepts only
// non-null carriers, drops pilots and packs data-carrier sign bits into words.
module qpsk_demap
    import qpsk_demap_pkg::*;
#(
    parameter int NCAR = qpsk_demap_pkg::NCAR
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic [31:0]         DAT_I,
    input  logic                WE_I,
    input  logic                STB_I,
    input  logic                CYC_I,
    output logic                ACK_O,
    output logic [31:0]         DAT_O,
    output logic                CYC_O,
    output logic                STB_O,
    output logic                WE_O,
    input  logic                ACK_I,
    input  logic [2*NCAR-1:0]   ALLOC_VEC,
    output logic                VEC_LD
);

    localparam int            PW       = (NCAR > 1) ? $clog2(NCAR) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(NCAR - 1);

    state_e            state_r;
    state_e            state_nx_s;
    logic [PW-1:0]     ptr_r;
    logic [PW-1:0]     ptr_nx_s;
    logic [2*NCAR-1:0] alloc_r;
    logic              cyc_prev_r;
    logic              vec_ld_r;
    logic              cyc_o_r;

    logic              in_val_s;
    logic              cyc_rise_s;
    logic              out_halt_s;
    logic              ack_s;
    logic              last_s;
    logic              load_s;
    logic              push_s;
    logic              flush_s;
    logic [1:0]        code_s;
    logic [1:0]        pair_s;
    logic [31:0]       word_s;
    logic              word_vld_s;
    logic [3:0]        fill_s;
    logic              unused_s;

    // Only the sign bits matter for hard decisions; magnitudes are ignored
    assign unused_s = ^{DAT_I[30:16], DAT_I[14:0]};

    assign in_val_s   = WE_I & STB_I & CYC_I;
    assign cyc_rise_s = CYC_I & ~cyc_prev_r;
    assign ack_s      = in_val_s & (state_r == ST_RUN) & ~out_halt_s;
    assign code_s     = alloc_r[{ptr_r, 1'b0} +: 2];
    assign last_s     = (ptr_r == PTR_LAST);
    assign pair_s     = {DAT_I[31], DAT_I[15]};

    // Next-state, carrier pointer and packer control
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        load_s     = 1'b0;
        push_s     = 1'b0;
        flush_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cyc_rise_s) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_s     = 1'b1;
                ptr_nx_s   = '0;
                state_nx_s = ST_SCAN;
            end
            ST_SCAN: begin
                if (code_s != ALLOC_NULL) begin
                    state_nx_s = ST_RUN;
                end else if (last_s) begin
                    state_nx_s = ST_FLUSH;
                end else begin
                    ptr_nx_s = ptr_r + PW'(1);
                end
            end
            ST_RUN: begin
                // Without a sample (e.g. CYC_I dropped) the FSM simply waits here
                if (ack_s) begin
                    push_s = is_data(code_s);
                    if (last_s) begin
                        state_nx_s = ST_FLUSH;
                    end else begin
                        ptr_nx_s   = ptr_r + PW'(1);
                        state_nx_s = ST_SCAN;
                    end
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_s = 1'b1;
                // Leave once there is nothing to flush or the output slot frees up
                if ((fill_s == 4'd0) || !out_halt_s) begin
                    if (CYC_I) begin
                        state_nx_s = ST_LOAD;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_FLUSH;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, pointer, allocation latch and registered status outputs
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            alloc_r    <= '0;
            cyc_prev_r <= 1'b1;
            vec_ld_r   <= 1'b0;
            cyc_o_r    <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            ptr_r      <= ptr_nx_s;
            cyc_prev_r <= CYC_I;
            vec_ld_r   <= load_s;
            if (load_s) begin
                alloc_r <= ALLOC_VEC;
            end
            if (ack_s) begin
                cyc_o_r <= 1'b1;
            end else if ((state_r == ST_IDLE) && !word_vld_s && (fill_s == 4'd0)) begin
                cyc_o_r <= 1'b0;
            end
        end
    end

    qpsk_bitpack u_bitpack (
        .clk      (CLK_I),
        .rst      (RST_I),
        .push     (push_s),
        .pair     (pair_s),
        .flush    (flush_s),
        .ack      (ACK_I),
        .word     (word_s),
        .word_vld (word_vld_s),
        .fill     (fill_s),
        .halt     (out_halt_s)
    );

    assign ACK_O  = ack_s;
    assign DAT_O  = word_s;
    assign STB_O  = word_vld_s;
    assign CYC_O  = cyc_o_r;
    assign WE_O   = cyc_o_r;
    assign VEC_LD = vec_ld_r;

endmodule

// File: tb/tb_qpsk_demap.sv
// Directed self-checking bench for qpsk_demap with hand-computed expected words.
module tb_qpsk_demap;

    localparam logic [31:0] S_PP = 32'h2000_2000; // Re+, Im+ -> pair 00
    localparam logic [31:0] S_NN = 32'hE000_E000; // Re-, Im- -> pair 11
    localparam logic [31:0] S_PN = 32'hE000_2000; // Re+, Im- -> pair 10
    localparam logic [31:0] S_NP = 32'h2000_E000; // Re-, Im+ -> pair 01

    logic         clk;
    logic         RST_I;
    logic [31:0]  DAT_I;
    logic         WE_I;
    logic         STB_I;
    logic         CYC_I;
    logic         ACK_O;
    logic [31:0]  DAT_O;
    logic         CYC_O;
    logic         STB_O;
    logic         WE_O;
    logic         ACK_I;
    logic [399:0] ALLOC_VEC;
    logic         VEC_LD;

    int          n_cmp;
    int          n_err;
    int          n_vld;
    int          n_ack;
    logic [31:0] words[$];
    logic [31:0] smp[$];
    logic [31:0] exp_q[$];

    qpsk_demap dut (
        .CLK_I     (clk),
        .RST_I     (RST_I),
        .DAT_I     (DAT_I),
        .WE_I      (WE_I),
        .STB_I     (STB_I),
        .CYC_I     (CYC_I),
        .ACK_O     (ACK_O),
        .DAT_O     (DAT_O),
        .CYC_O     (CYC_O),
        .STB_O     (STB_O),
        .WE_O      (WE_O),
        .ACK_I     (ACK_I),
        .ALLOC_VEC (ALLOC_VEC),
        .VEC_LD    (VEC_LD)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output monitor: collects accepted words and counts pulses on the falling edge
    always @(negedge clk) begin
        if (!RST_I) begin
            if (STB_O && ACK_I) words.push_back(DAT_O);
            if (VEC_LD) n_vld <= n_vld + 1;
            if (ACK_O) n_ack <= n_ack + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_words(input string tag, input int base);
        chk({tag, "_nwords"}, 32'(words.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < words.size())
                chk($sformatf("%s_word%0d", tag, i), words[base + i], exp_q[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack_o"},  32'(ACK_O),  32'd0);
        chk({tag, "_stb_o"},  32'(STB_O),  32'd0);
        chk({tag, "_cyc_o"},  32'(CYC_O),  32'd0);
        chk({tag, "_we_o"},   32'(WE_O),   32'd0);
        chk({tag, "_vec_ld"}, 32'(VEC_LD), 32'd0);
        chk({tag, "_dat_o"},  DAT_O,       32'd0);
    endtask

    function automatic logic [399:0] alloc_fill(input int n, input logic [1:0] code);
        logic [399:0] a;
        a = '0;
        for (int k = 0; k < n; k++) a[2*k +: 2] = code;
        return a;
    endfunction

    // 8 pilots at k%25==12, 192 data carriers
    function automatic logic [399:0] alloc_std();
        logic [399:0] a;
        a = '0;
        for (int k = 0; k < 200; k++) a[2*k +: 2] = ((k % 25) == 12) ? 2'b10 : 2'b01;
        return a;
    endfunction

    // 100 pilots, then 32 data, then nulls
    function automatic logic [399:0] alloc_b2b();
        logic [399:0] a;
        a = '0;
        for (int k = 0; k < 132; k++) a[2*k +: 2] = (k < 100) ? 2'b10 : 2'b01;
        return a;
    endfunction

    task automatic load_std_samples();
        smp.delete();
        for (int k = 0; k < 200; k++) smp.push_back(((k % 25) == 12) ? S_NN : S_PN);
    endtask

    task automatic load_alt17_samples();
        smp.delete();
        for (int k = 0; k < 17; k++) smp.push_back(((k % 2) == 0) ? S_PP : S_NN);
    endtask

    // Present up to nsend samples from smp, each held until ACK_O accepts it
    task automatic run_symbol(input logic [399:0] alloc, input int nsend, input bit keep_cyc);
        int lim;
        int w;
        lim = (nsend < smp.size()) ? nsend : smp.size();
        ALLOC_VEC = alloc;
        CYC_I = 1'b1;
        WE_I  = 1'b1;
        STB_I = 1'b1;
        for (int i = 0; i < lim; i++) begin
            DAT_I = smp[i];
            w = 0;
            @(negedge clk);
            while (!ACK_O && w < 2000) begin
                @(negedge clk);
                w++;
            end
            if (!ACK_O) begin
                chk("ack_timeout", 32'(ACK_O), 32'd1);
                break;
            end
            @(posedge clk);
            #1;
        end
        STB_I = 1'b0;
        WE_I  = 1'b0;
        DAT_I = 32'd0;
        if (!keep_cyc) CYC_I = 1'b0;
    endtask

    // Wait (bounded) for the output burst to close, then confirm CYC_O is low
    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        @(negedge clk);
        while ((CYC_O || STB_O) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_cyc_o_low"}, 32'(CYC_O), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Hold ACK_I low for 5 cycles on the first word and check it stays put
    task automatic stall_first_word();
        int w;
        w = 0;
        @(negedge clk);
        while (!STB_O && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("stall_stb_seen", 32'(STB_O), 32'd1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("stall_stb_%0d", c), 32'(STB_O), 32'd1);
            chk($sformatf("stall_dat_%0d", c), DAT_O, 32'hE4E4_E4E4);
            chk($sformatf("stall_ack_o_%0d", c), 32'(ACK_O), 32'd0);
        end
        @(posedge clk);
        #1;
        ACK_I = 1'b1;
    endtask

    initial begin
        int bw;
        int bv;
        int ba;
        n_cmp = 0;
        n_err = 0;
        n_vld = 0;
        n_ack = 0;
        RST_I = 1'b1;
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
        DAT_I = 32'd0;
        ACK_I = 1'b1;
        ALLOC_VEC = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        RST_I = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Standard symbol: 8 pilots + 192 data, Re=+, Im=- -> 12 x 0xAAAAAAAA
        bw = words.size(); bv = n_vld; ba = n_ack;
        load_std_samples();
        run_symbol(alloc_std(), 200, 1'b0);
        wait_idle("std");
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(32'hAAAA_AAAA);
        check_words("std", bw);
        chk("std_vec_ld", 32'(n_vld - bv), 32'd1);
        chk("std_acks", 32'(n_ack - ba), 32'd200);

        // 17 data carriers alternating (+,+)/(-,-): one full word plus a flushed pair 00
        bw = words.size(); bv = n_vld; ba = n_ack;
        load_alt17_samples();
        run_symbol(alloc_fill(17, 2'b01), 17, 1'b0);
        wait_idle("alt17");
        exp_q = '{32'hCCCC_CCCC, 32'h0000_0000};
        check_words("alt17", bw);
        chk("alt17_vec_ld", 32'(n_vld - bv), 32'd1);
        chk("alt17_acks", 32'(n_ack - ba), 32'd17);

        // Back-pressure: 40 data carriers (code 11), pairs 00,01,10,11 repeating
        bw = words.size(); ba = n_ack;
        smp.delete();
        for (int k = 0; k < 40; k++) begin
            case (k % 4)
                0:       smp.push_back(S_PP);
                1:       smp.push_back(S_NP);
                2:       smp.push_back(S_PN);
                default: smp.push_back(S_NN);
            endcase
        end
        ACK_I = 1'b0;
        fork
            run_symbol(alloc_fill(40, 2'b11), 40, 1'b0);
            stall_first_word();
        join
        wait_idle("stall");
        exp_q = '{32'hE4E4_E4E4, 32'hE4E4_E4E4, 32'h0000_E4E4};
        check_words("stall", bw);
        chk("stall_acks", 32'(n_ack - ba), 32'd40);

        // All pilots: every sample accepted, no word emitted
        bw = words.size(); ba = n_ack;
        smp.delete();
        for (int k = 0; k < 200; k++) smp.push_back(S_NN);
        run_symbol(alloc_fill(200, 2'b10), 200, 1'b0);
        chk("pilot_cyc_o_high", 32'(CYC_O), 32'd1);
        wait_idle("pilot");
        exp_q.delete();
        check_words("pilot", bw);
        chk("pilot_acks", 32'(n_ack - ba), 32'd200);

        // Reset after carrier 50 (49 data: 3 words out, 1 pair pending)
        bw = words.size();
        load_std_samples();
        run_symbol(alloc_std(), 51, 1'b1);
        RST_I = 1'b1;
        CYC_I = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        RST_I = 1'b0;
        repeat (4) @(negedge clk);
        exp_q = '{32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
        check_words("midrst_pre", bw);
        @(posedge clk);
        #1;
        bw = words.size(); bv = n_vld;
        load_alt17_samples();
        run_symbol(alloc_fill(17, 2'b01), 17, 1'b0);
        wait_idle("midrst_post");
        exp_q = '{32'hCCCC_CCCC, 32'h0000_0000};
        check_words("midrst_post", bw);
        chk("midrst_vec_ld", 32'(n_vld - bv), 32'd1);

        // Back-to-back symbols with CYC_I held high and a different second vector
        bw = words.size(); bv = n_vld; ba = n_ack;
        load_alt17_samples();
        run_symbol(alloc_fill(17, 2'b01), 17, 1'b1);
        smp.delete();
        for (int k = 0; k < 132; k++) smp.push_back((k < 100) ? S_NN : S_PN);
        run_symbol(alloc_b2b(), 132, 1'b0);
        wait_idle("b2b");
        exp_q = '{32'hCCCC_CCCC, 32'h0000_0000, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
        check_words("b2b", bw);
        chk("b2b_vec_ld", 32'(n_vld - bv), 32'd2);
        chk("b2b_acks", 32'(n_ack - ba), 32'd149);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
